// File: rtl/cam_pkg.sv
// Shared types and defaults for the CAM event queue slice.
package cam_pkg;

    localparam int unsigned CAM_DEPTH_LOG2 = 4;
    localparam int unsigned CAM_DROP_W     = 16;
    localparam int unsigned CAM_WORD_W     = 32;
    localparam int unsigned CAM_SEQ_W      = 4;

    typedef logic [CAM_WORD_W-1:0] cam_word_t;

    // Event word with its top nibble repurposed as a push sequence tag
    typedef struct packed {
        logic [CAM_SEQ_W-1:0]            seq;
        logic [CAM_WORD_W-CAM_SEQ_W-1:0] payload;
    } cam_tagged_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD
    } state_t;

endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock FIFO with separate occupancy counter; the caller owns overflow policy.
module cam_sync_fifo
    import cam_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = CAM_DEPTH_LOG2
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                push,
    input  cam_word_t           wdata,
    input  logic                pop,
    output cam_word_t           rdata,
    output logic [DEPTH_LOG2:0] level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    cam_word_t             mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: level gates every read
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cam_event_queue.sv
// Event FIFO feeding the CAM-port serializer, paced against its busy flag.
// Optional: define CAM_EVENT_QUEUE_SEQ_EN to tag bits [31:28] of accepted words with a push sequence number.
module cam_event_queue
    import cam_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = CAM_DEPTH_LOG2,
    parameter int unsigned DROP_W     = CAM_DROP_W
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                ev_valid_i,
    input  logic [31:0]         ev_data_i,
    input  logic                ser_busy_i,
    output logic                ser_wr_o,
    output logic [31:0]         ser_data_o,
    output logic [DEPTH_LOG2:0] level_o,
    output logic                overflow_o,
    output logic [DROP_W-1:0]   drop_count_o,
    input  logic                clr_overflow_i
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    state_t    state;
    state_t    state_d;
    logic      ser_wr_d;
    cam_word_t ser_data_d;
    cam_word_t head;
    cam_word_t push_word;
    logic      pop_c;
    logic      push_c;
    logic      drop_c;
    logic      full_c;

    cam_sync_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .push (push_c),
        .wdata(push_word),
        .pop  (pop_c),
        .rdata(head),
        .level(level_o)
    );

    // Drain FSM: pop, strobe for one cycle, then skip the cycle where busy still reflects the old write
    always_comb begin
        state_d    = state;
        ser_wr_d   = 1'b0;
        ser_data_d = ser_data_o;
        pop_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if ((level_o != '0) && !ser_busy_i) begin
                    pop_c      = 1'b1;
                    ser_wr_d   = 1'b1;
                    ser_data_d = head;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ser_wr_o   <= 1'b0;
            ser_data_o <= '0;
        end else begin
            state      <= state_d;
            ser_wr_o   <= ser_wr_d;
            ser_data_o <= ser_data_d;
        end
    end

    // A full FIFO still accepts when the head leaves in the same cycle
    always_comb begin
        full_c = (level_o == LVL_W'(DEPTH));
        push_c = ev_valid_i && (!full_c || pop_c);
        drop_c = ev_valid_i && !push_c;
    end

`ifdef CAM_EVENT_QUEUE_SEQ_EN
    logic [CAM_SEQ_W-1:0] seq_q;
    cam_tagged_t          tagged_c;

    always_comb begin
        tagged_c.seq     = seq_q;
        tagged_c.payload = ev_data_i[CAM_WORD_W-CAM_SEQ_W-1:0];
        push_word        = cam_word_t'(tagged_c);
    end

    // Only accepted pushes advance the tag, so drops show up as a count, not a tag gap
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= '0;
        end else if (push_c) begin
            seq_q <= seq_q + CAM_SEQ_W'(1);
        end
    end
`else
    assign push_word = ev_data_i;
`endif

    // Clear takes effect first, so a drop in the same cycle counts as one
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (clr_overflow_i) begin
            overflow_o   <= drop_c;
            drop_count_o <= DROP_W'(drop_c);
        end else if (drop_c) begin
            overflow_o <= 1'b1;
            if (drop_count_o != '1) drop_count_o <= drop_count_o + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_cam_event_queue.sv
// Self-checking bench for cam_event_queue against a queue-based behavioural model.
module tb_cam_event_queue;
    import cam_pkg::*;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned DROP_MAX = 65535;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        ev_valid_i;
    logic [31:0] ev_data_i;
    logic        ser_busy_i;
    logic        ser_wr_o;
    logic [31:0] ser_data_o;
    logic [4:0]  level_o;
    logic        overflow_o;
    logic [15:0] drop_count_o;
    logic        clr_overflow_i;

    always #5 clk_i = ~clk_i;

    cam_event_queue dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .ev_valid_i    (ev_valid_i),
        .ev_data_i     (ev_data_i),
        .ser_busy_i    (ser_busy_i),
        .ser_wr_o      (ser_wr_o),
        .ser_data_o    (ser_data_o),
        .level_o       (level_o),
        .overflow_o    (overflow_o),
        .drop_count_o  (drop_count_o),
        .clr_overflow_i(clr_overflow_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mq[$];
    bit          m_wr   = 1'b0;
    logic [31:0] m_data = '0;
    bit          m_ovf  = 1'b0;
    int unsigned m_drop = 0;
    int          m_gap  = 0;
    int unsigned m_seq  = 0;
    bit          m_pop, m_acc, m_drp;
    logic [31:0] m_w;

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_wr = 1'b0; m_data = '0; m_ovf = 1'b0; m_drop = 0; m_gap = 0; m_seq = 0;
        end else begin
            m_pop = (m_gap == 0) && (mq.size() != 0) && !ser_busy_i;
            m_acc = ev_valid_i && ((mq.size() < DEPTH) || m_pop);
            m_drp = ev_valid_i && !m_acc;
            m_wr  = m_pop;
            if (m_pop) begin
                m_data = mq.pop_front();
                m_gap  = 2;
            end else if (m_gap > 0) begin
                m_gap--;
            end
            if (m_acc) begin
                m_w = ev_data_i;
`ifdef CAM_EVENT_QUEUE_SEQ_EN
                m_w[31:28] = 4'(m_seq);
`endif
                mq.push_back(m_w);
                m_seq = (m_seq + 1) % 16;
            end
            if (clr_overflow_i) begin
                m_ovf = 1'b0; m_drop = 0;
            end
            if (m_drp) begin
                m_ovf = 1'b1;
                if (m_drop < DROP_MAX) m_drop++;
            end
        end
    end

    // ---------------- compare process ----------------
    bit          chk_en   = 1'b0;
    int          since_wr = 99;
    int          wr_cnt   = 0;
    logic [31:0] iss_q[$];

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("wr",    32'(ser_wr_o),     32'(m_wr));
            chk("data",  ser_data_o,        m_data);
            chk("level", 32'(level_o),      32'(mq.size()));
            chk("ovf",   32'(overflow_o),   32'(m_ovf));
            chk("drop",  32'(drop_count_o), m_drop);
            if (!rst_n) begin
                since_wr = 99;
            end else if (ser_wr_o) begin
                chk("spacing", 32'(since_wr >= 3), 32'd1);
                since_wr = 1;
                wr_cnt++;
                iss_q.push_back(ser_data_o);
            end else begin
                since_wr++;
            end
        end
    end

    // ---------------- stimulus ----------------
    int  bmode      = 2;   // 0 random, 1 serializer stub, 2 forced
    int  busy_pct   = 50;
    int  stub_len   = 40;
    int  busy_left  = 0;
    bit  busy_force = 1'b0;
    bit  wr_prev    = 1'b0;

    // Advance one clock; inputs change 2 time units after the edge
    task automatic cyc();
        @(posedge clk_i);
        #2;
        case (bmode)
            0: ser_busy_i = ($urandom_range(99) < 32'(busy_pct));
            1: begin
                if (wr_prev) busy_left = stub_len;
                ser_busy_i = (busy_left > 0);
                if (busy_left > 0) busy_left--;
            end
            default: ser_busy_i = busy_force;
        endcase
        wr_prev = ser_wr_o;
    endtask

    task automatic push(input logic [31:0] w);
        ev_valid_i = 1'b1;
        ev_data_i  = w;
        cyc();
        ev_valid_i = 1'b0;
    endtask

    initial begin
        int          base;
        int          k;
        logic [3:0]  exp_top;
        logic [31:0] got;

        rst_n = 1'b0; ev_valid_i = 1'b0; ev_data_i = '0;
        ser_busy_i = 1'b0; clr_overflow_i = 1'b0;
        repeat (2) cyc();
        chk_en = 1'b1;
        chk("rst_wr",    32'(ser_wr_o),     32'd0);
        chk("rst_data",  ser_data_o,        32'd0);
        chk("rst_level", 32'(level_o),      32'd0);
        chk("rst_ovf",   32'(overflow_o),   32'd0);
        chk("rst_drop",  32'(drop_count_o), 32'd0);
        rst_n = 1'b1;
        repeat (3) cyc();

        // single word latency
        bmode = 2; busy_force = 1'b0;
        push(32'hDEADBEEF);
        chk("t1_level1", 32'(level_o),  32'd1);
        chk("t1_wr0",    32'(ser_wr_o), 32'd0);
        cyc();
        chk("t1_wr1",    32'(ser_wr_o), 32'd1);
        chk("t1_data",   ser_data_o,    32'hDEADBEEF);
        chk("t1_level0", 32'(level_o),  32'd0);
        cyc();
        chk("t1_wr_once", 32'(ser_wr_o), 32'd0);
        chk("t1_hold",    ser_data_o,    32'hDEADBEEF);
        repeat (3) cyc();

        // three words paced by a 40-cycle serializer busy
        bmode = 1; stub_len = 40; busy_left = 0;
        base = wr_cnt;
        push(32'h1111_0001); push(32'h2222_0002); push(32'h3333_0003);
        repeat (200) cyc();
        chk("t2_pulses", 32'(wr_cnt - base), 32'd3);

        // overflow with busy held high
        bmode = 2; busy_force = 1'b1;
        repeat (3) cyc();
        for (int i = 0; i < 20; i++) push(32'hA000_0000 + 32'(i));
        chk("t3_level", 32'(level_o),      32'd16);
        chk("t3_ovf",   32'(overflow_o),   32'd1);
        chk("t3_drop",  32'(drop_count_o), 32'd4);

        // full FIFO: push and pop in the same cycle
        busy_force = 1'b0; ser_busy_i = 1'b0;
        ev_valid_i = 1'b1; ev_data_i = 32'hBBBB_0016;
        cyc();
        ev_valid_i = 1'b0;
        busy_force = 1'b1; ser_busy_i = 1'b1;
        chk("t4_level", 32'(level_o),      32'd16);
        chk("t4_drop",  32'(drop_count_o), 32'd4);
        chk("t4_wr",    32'(ser_wr_o),     32'd1);
        chk("t4_head",  ser_data_o,        32'hA000_0000);

        // clear with and without a same-cycle drop
        ev_valid_i = 1'b1; ev_data_i = 32'hCCCC_0000; clr_overflow_i = 1'b1;
        cyc();
        ev_valid_i = 1'b0;
        chk("t5_drop1", 32'(drop_count_o), 32'd1);
        chk("t5_ovf1",  32'(overflow_o),   32'd1);
        cyc();
        clr_overflow_i = 1'b0;
        chk("t5_drop0", 32'(drop_count_o), 32'd0);
        chk("t5_ovf0",  32'(overflow_o),   32'd0);
        busy_force = 1'b0;
        repeat (80) cyc();

        // reset while a write is being issued
        busy_force = 1'b1; ser_busy_i = 1'b1;
        repeat (3) cyc();
        for (int i = 0; i < 5; i++) push(32'h5500_0000 + 32'(i));
        busy_force = 1'b0; ser_busy_i = 1'b0;
        k = 0;
        while (!ser_wr_o && k < 10) begin
            cyc();
            k++;
        end
        chk("t6_issue_seen", 32'(ser_wr_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_wr",    32'(ser_wr_o),     32'd0);
        chk("t6_data",  ser_data_o,        32'd0);
        chk("t6_level", 32'(level_o),      32'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        base = wr_cnt;
        repeat (20) cyc();
        chk("t6_no_wr", 32'(wr_cnt - base), 32'd0);

        // 17 pushes after reset: tags 0..15 then 0 when tagging is built in
        iss_q.delete();
        for (int i = 0; i < 17; i++) push(32'hF000_0000 + 32'(i));
        repeat (80) cyc();
        chk("seq_count", 32'(iss_q.size()), 32'd17);
        for (int i = 0; i < 17 && i < iss_q.size(); i++) begin
`ifdef CAM_EVENT_QUEUE_SEQ_EN
            exp_top = 4'(i % 16);
`else
            exp_top = 4'hF;
`endif
            got = iss_q[i];
            chk("seq_tag",  32'(got[31:28]), 32'(exp_top));
            chk("seq_body", 32'(got[27:0]),  32'(i));
        end

        // randomized traffic across busy modes
        for (int ph = 0; ph < 6; ph++) begin
            bmode    = ph % 3;
            busy_pct = 20 + 15 * ph;
            stub_len = 1 + (ph % 8);
            busy_force = 1'b0;
            for (int c = 0; c < 500; c++) begin
                ev_valid_i     = ($urandom_range(99) < 32'(30 + 10 * ph));
                ev_data_i      = $urandom;
                clr_overflow_i = ($urandom_range(49) == 0);
                cyc();
            end
        end
        ev_valid_i = 1'b0; clr_overflow_i = 1'b0;
        bmode = 2; busy_force = 1'b0;
        repeat (80) cyc();
        chk("final_empty", 32'(level_o), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
